// File: rtl/ysyx_23060208_mem_arbiter.sv
// rtl/ysyx_23060208_mem_arbiter.sv - round-robin N-master to single-slave memory arbiter
// One transaction outstanding at a time; timeouts complete with err=1 and rdata=0.
module ysyx_23060208_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_MST      = 2,
  parameter int TIMEOUT    = 16,
  localparam int GW        = $clog2(N_MST),
  localparam int SW        = DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MST-1:0]            m_req_valid,
  output logic [N_MST-1:0]            m_req_ready,
  input  logic [N_MST*ADDR_WIDTH-1:0] m_req_addr,
  input  logic [N_MST-1:0]            m_req_wen,
  input  logic [N_MST*DATA_WIDTH-1:0] m_req_wdata,
  input  logic [N_MST*SW-1:0]         m_req_wstrb,
  output logic [N_MST-1:0]            m_rsp_valid,
  input  logic [N_MST-1:0]            m_rsp_ready,
  output logic [DATA_WIDTH-1:0]       m_rsp_rdata,
  output logic                        m_rsp_err,
  output logic                        s_req_valid,
  input  logic                        s_req_ready,
  output logic [ADDR_WIDTH-1:0]       s_req_addr,
  output logic                        s_req_wen,
  output logic [DATA_WIDTH-1:0]       s_req_wdata,
  output logic [SW-1:0]               s_req_wstrb,
  input  logic                        s_rsp_valid,
  output logic                        s_rsp_ready,
  input  logic [DATA_WIDTH-1:0]       s_rsp_rdata,
  output logic [GW-1:0]               grant_id
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         gnt_q, gnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  pick_found;
  logic [GW-1:0]         pick_idx;
  logic [N_MST-1:0]      req_ready_c;

  // First requesting master at or after rr_ptr, wrapping past N_MST-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_MST; k++) begin
      if (!pick_found && m_req_valid[(int'(rr_ptr_q) + k) % N_MST]) begin
        pick_found = 1'b1;
        pick_idx   = GW'((int'(rr_ptr_q) + k) % N_MST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_c = '0;
    s_req_valid = 1'b0;
    m_rsp_valid = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          req_ready_c[pick_idx] = 1'b1;
          gnt_d   = pick_idx;
          addr_d  = m_req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wen_d   = m_req_wen[pick_idx];
          wdata_d = m_req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          wstrb_d = m_req_wstrb[pick_idx*SW +: SW];
          state_d = REQ;
        end
      end
      REQ: begin
        s_req_valid = 1'b1;
        if (s_req_ready) begin
          cnt_d   = '0;
          state_d = RSP;
        end
      end
      RSP: begin
        // A response in the final wait cycle beats the timeout.
        if (s_rsp_valid) begin
          rdata_d = s_rsp_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        m_rsp_valid[gnt_q] = 1'b1;
        if (m_rsp_ready[gnt_q]) begin
          rr_ptr_d = GW'((int'(gnt_q) + 1) % N_MST);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant pick is combinational on m_req_valid, so keep it quiet while held in reset.
  assign m_req_ready = req_ready_c & {N_MST{rst}};
  assign s_req_addr  = addr_q;
  assign s_req_wen   = wen_q;
  assign s_req_wdata = wdata_q;
  assign s_req_wstrb = wstrb_q;
  assign s_rsp_ready = 1'b1;
  assign m_rsp_rdata = rdata_q;
  assign m_rsp_err   = err_q;
  assign grant_id    = (state_q == IDLE) ? rr_ptr_q : gnt_q;

endmodule

// File: doc/ysyx_23060208_mem_arbiter.md
YSYX_23060208_MEM_ARBITER -- requirements
Module: ysyx_23060208_mem_arbiter

Interface
REQ-001 Parameters SHALL be DATA_WIDTH, default 32, data bus width; ADDR_WIDTH, default 32, address width; N_MST, default 2 (range 2..8), number of master channels; TIMEOUT, default 16, maximum slave response wait in cycles (0 = no timeout).
REQ-002 Ports SHALL be as listed (one clock; reset is asynchronous and active-low):
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
m_req_valid  in  N_MST  per-master request valid
m_req_ready  out  N_MST  per-master request accept
m_req_addr  in  N_MST*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_req_wen  in  N_MST  1 = write, 0 = read
m_req_wdata  in  N_MST*DATA_WIDTH  packed write data
m_req_wstrb  in  N_MST*DATA_WIDTH/8  packed byte strobes
m_rsp_valid  out  N_MST  per-master response valid
m_rsp_ready  in  N_MST  per-master response accept
m_rsp_rdata  out  DATA_WIDTH  shared response data
m_rsp_err  out  1  shared response error (timeout)
s_req_valid  out  1  slave request valid
s_req_ready  in  1  slave request accept
s_req_addr  out  ADDR_WIDTH  slave address
s_req_wen  out  1  slave write enable
s_req_wdata  out  DATA_WIDTH  slave write data
s_req_wstrb  out  DATA_WIDTH/8  slave byte strobes
s_rsp_valid  in  1  slave response valid
s_rsp_ready  out  1  slave response accept
s_rsp_rdata  in  DATA_WIDTH  slave read data
grant_id  out  clog2(N_MST)  index of master currently owning the slave

Function
REQ-003 The block SHALL implement a four-state FSM: IDLE, REQ, RSP, DONE.
REQ-004 IDLE: if any m_req_valid bit is set, the block SHALL select grant g = first set index at or after rr_ptr, ascending with wrap past N_MST-1 to 0.
REQ-005 IDLE: m_req_ready[g] SHALL be asserted combinationally in that cycle only; all other m_req_ready bits SHALL be 0.
REQ-006 On that edge the block SHALL latch g plus master g's addr/wen/wdata/wstrb into internal registers, and SHALL move to REQ.
REQ-007 REQ: s_req_valid SHALL be 1 with the latched payload; on s_req_valid && s_req_ready the block SHALL move to RSP and clear the wait counter.
REQ-008 RSP: the block SHALL increment the wait counter each cycle.
REQ-009 RSP: on s_rsp_valid it SHALL latch s_rsp_rdata, clear the error flag, and move to DONE.
REQ-010 RSP: if TIMEOUT>0 and the counter reaches TIMEOUT-1 without s_rsp_valid, the block SHALL latch rdata=0 and error=1, then move to DONE.
REQ-011 If s_rsp_valid coincides with the timeout cycle, the response SHALL win (err=0).
REQ-012 DONE: m_rsp_valid[g] SHALL be 1, with m_rsp_rdata and m_rsp_err showing the latched values; on m_rsp_ready[g] the block SHALL set rr_ptr = (g+1) mod N_MST and return to IDLE.
REQ-013 A write SHALL complete exactly like a read, with one slave response; m_rsp_rdata SHALL carry the slave value unchanged.
REQ-014 s_rsp_ready SHALL be constantly 1; responses arriving outside RSP, including late responses after a timeout, SHALL be discarded without state change.
REQ-015 Minimum latency, m_req_valid to m_rsp_valid with zero-wait slave, SHALL be 3 cycles; at most one transaction SHALL be outstanding.
REQ-016 Requests arriving from non-granted masters while busy SHALL see m_req_ready=0 until a later IDLE grant.
REQ-017 Masters SHALL hold request payload stable until accepted; the block SHALL NOT rely on payload after the acceptance edge.
REQ-018 grant_id SHALL show the latched g in REQ/RSP/DONE and rr_ptr in IDLE.

Reset
REQ-019 While rst=0, the block SHALL set state=IDLE, rr_ptr=0, wait counter=0, latched payload/rdata/err=0, all outputs 0 except s_rsp_ready=1, independent of clk.
REQ-020 Reset asserted mid-transaction SHALL abandon it with no response to any master; after deassertion the first grant SHALL use rr_ptr=0.

Verification
REQ-021 N_MST=2, zero-wait slave, master0 reads addr 0x80000010, slave returns 0xDEADBEEF -> m_rsp_valid[0] 3 cycles after request, rdata=0xDEADBEEF, err=0.
REQ-022 Both masters request continuously from reset -> grants alternate 0,1,0,1; neither is starved.
REQ-023 Master1 writes 0x12345678, wstrb=4'b0011, to 0x80000100 -> slave sees exactly that payload once; master1 gets m_rsp_valid with err=0.
REQ-024 TIMEOUT=16, slave never responds -> m_rsp_err=1, rdata=0 after 16 RSP cycles; a late s_rsp_valid is discarded and the next transaction is unaffected.
REQ-025 rst pulled low while in RSP -> all m_rsp_valid=0 immediately, state IDLE; a master1 request after release is served normally.
REQ-026 Slave holds s_req_ready=0 for 5 cycles and master holds m_rsp_ready=0 for 3 cycles -> s_req_* and m_rsp_* stay stable throughout; single completion.
